// File: rtl/spi_ram_burst_slave.sv
// spi_ram_burst_slave: SPI slave with built-in RAM, burst read/write with address wrap and frame-error reporting.
// Ports:
//   clk       - serial clock; MOSI and SS_n are sampled on its rising edge
//   rst_n     - asynchronous active-low reset
//   MOSI      - serial data in, MSB first
//   SS_n      - active-low slave select; one low period is one frame
//   MISO      - registered serial data out, low outside read bursts
//   frame_err - one-cycle error pulse (bad address, aborted frame, parity error)
// Frame: 2 command bits (00 wr addr, 01 wr data, 10 rd addr, 11 rd data) then payload.
// Build option: define SPI_RAM_PARITY_EN to add an even-parity bit after every data word.
module spi_ram_burst_slave #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MOSI,
    input  logic SS_n,
    output logic MISO,
    output logic frame_err
);
`ifdef SPI_RAM_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int WL  = DATA_W + PAR;
    localparam int PW  = $clog2(DEPTH);
    localparam int SW0 = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int SW  = (SW0 > 2) ? SW0 : 2;
    localparam int MX  = (ADDR_W > WL) ? ADDR_W : WL;
    localparam int CW  = $clog2(MX + 1);
    localparam int AW1 = ADDR_W + 1;
    localparam logic [PW-1:0]  LAST  = PW'(DEPTH - 1);
    localparam logic [AW1-1:0] LIMIT = AW1'(DEPTH);
    localparam logic [CW-1:0]  A_END = CW'(ADDR_W - 1);
    localparam logic [CW-1:0]  W_END = CW'(WL - 1);
    // Payload states carry the command in their low bits so decode is a concatenation.
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CMD     = 3'd1;
    localparam logic [2:0] DONE    = 3'd2;
    localparam logic [2:0] WR_ADDR = 3'd4;
    localparam logic [2:0] WR_DATA = 3'd5;
    localparam logic [2:0] RD_ADDR = 3'd6;
    localparam logic [2:0] RD_DATA = 3'd7;

    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     sr;
    logic [WL-1:0]     tx;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [SW-1:0]     sr_nx;
    logic [ADDR_W-1:0] addr;
    logic              addr_bad;
    logic [PW-1:0]     addr_ptr, wr_inc, rd_inc;
    logic [DATA_W-1:0] rd_data, word_in;
    logic [WL-1:0]     tx_load;
    logic              par_ok, we;

    assign sr_nx    = SW'({sr, MOSI});
    assign addr     = ADDR_W'(sr_nx);
    assign addr_bad = {1'b0, addr} >= LIMIT;
    assign addr_ptr = addr_bad ? '0 : addr[PW-1:0];
    assign wr_inc   = (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
    assign rd_inc   = (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
    assign rd_data  = mem[rd_ptr];
`ifdef SPI_RAM_PARITY_EN
    // At the parity edge the completed word is already in sr and MOSI carries parity.
    assign word_in  = DATA_W'(sr);
    assign par_ok   = ~^{word_in, MOSI};
    assign tx_load  = {rd_data, ^rd_data};
`else
    assign word_in  = DATA_W'(sr_nx);
    assign par_ok   = 1'b1;
    assign tx_load  = rd_data;
`endif
    assign we = !SS_n && state == WR_DATA && cnt == W_END && par_ok;

    always_ff @(posedge clk)
        if (we) mem[wr_ptr] <= word_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            tx        <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            MISO      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sr        <= sr_nx;
            frame_err <= 1'b0;
            if (SS_n) begin
                // Abort: partial items are dropped; only incomplete command/address/write words are errors.
                state     <= IDLE;
                cnt       <= '0;
                MISO      <= 1'b0;
                frame_err <= state == CMD ||
                             ((state == WR_ADDR || state == RD_ADDR || state == WR_DATA) && cnt != '0);
            end else begin
                case (state)
                    IDLE: state <= CMD;
                    CMD: begin
                        state <= {1'b1, sr_nx[1:0]};
                        cnt   <= '0;
                        if (sr_nx[1:0] == 2'b11) begin
                            tx     <= tx_load;
                            rd_ptr <= rd_inc;
                        end
                    end
                    WR_ADDR, RD_ADDR: begin
                        cnt <= (cnt == A_END) ? '0 : cnt + 1'b1;
                        if (cnt == A_END) begin
                            state     <= DONE;
                            frame_err <= addr_bad;
                            if (state == WR_ADDR) wr_ptr <= addr_ptr;
                            else rd_ptr <= addr_ptr;
                        end
                    end
                    WR_DATA: begin
                        cnt <= (cnt == W_END) ? '0 : cnt + 1'b1;
                        if (cnt == W_END) begin
                            frame_err <= ~par_ok;
                            if (par_ok) wr_ptr <= wr_inc;
                        end
                    end
                    RD_DATA: begin
                        MISO <= tx[WL-1];
                        cnt  <= (cnt == W_END) ? '0 : cnt + 1'b1;
                        if (cnt == W_END) begin
                            tx     <= tx_load;
                            rd_ptr <= rd_inc;
                        end else begin
                            tx <= tx << 1;
                        end
                    end
                    default: MISO <= 1'b0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// tb_spi_ram_burst_slave: scoreboard bench for spi_ram_burst_slave (DATA_W=8, ADDR_W=8, DEPTH=200).
module tb_spi_ram_burst_slave;
    typedef struct {
        logic m;
        logic e;
        int   id;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic MOSI = 1'b0;
    logic SS_n = 1'b1;
    logic MISO, frame_err;
    exp_t q[$];
    exp_t mx;
    int total = 0;
    int bad = 0;
    int fid = 0;
    logic [7:0] w77 = 8'h77;

    spi_ram_burst_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(200)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .MOSI(MOSI),
        .SS_n(SS_n),
        .MISO(MISO),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Monitor: each queued entry is the expected output after one rising edge.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mx = q.pop_front();
            total++;
            if (MISO !== mx.m || frame_err !== mx.e) begin
                bad++;
                $display("FAIL frame%0d: MISO=%b frame_err=%b, required MISO=%b frame_err=%b",
                         mx.id, MISO, frame_err, mx.m, mx.e);
            end
        end
    end

    task automatic tick(input logic ss, input logic mosi, input logic em, input logic ee);
        exp_t x;
        @(negedge clk);
        SS_n = ss;
        MOSI = mosi;
        x.m = em;
        x.e = ee;
        x.id = fid;
        q.push_back(x);
    endtask

    task automatic open_frame(input logic [1:0] c);
        fid++;
        tick(1'b0, c[1], 1'b0, 1'b0);
        tick(1'b0, c[0], 1'b0, 1'b0);
    endtask

    task automatic close_frame(input logic ee);
        tick(1'b1, 1'b0, 1'b0, ee);
    endtask

    task automatic set_addr(input logic rd, input logic [7:0] a, input logic ee);
        open_frame({rd, 1'b0});
        for (int i = 7; i >= 0; i--) tick(1'b0, a[i], 1'b0, (i == 0) ? ee : 1'b0);
        close_frame(1'b0);
    endtask

    task automatic wr_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) tick(1'b0, w[i], 1'b0, 1'b0);
`ifdef SPI_RAM_PARITY_EN
        tick(1'b0, ^w, 1'b0, 1'b0);
`endif
    endtask

    task automatic rd_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) tick(1'b0, 1'b0, w[i], 1'b0);
`ifdef SPI_RAM_PARITY_EN
        tick(1'b0, 1'b0, ^w, 1'b0);
`endif
    endtask

`ifdef SPI_RAM_PARITY_EN
    task automatic wr_par(input logic [7:0] w, input logic p, input logic ee);
        for (int i = 7; i >= 0; i--) tick(1'b0, w[i], 1'b0, 1'b0);
        tick(1'b0, p, 1'b0, ee);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    initial begin
        #12;
        total++;
        if (MISO !== 1'b0 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL reset: MISO=%b frame_err=%b, required 0 0", MISO, frame_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        // write then read 0xA5 at 0x10
        set_addr(1'b0, 8'h10, 1'b0);
        open_frame(2'b01); wr_word(8'hA5); close_frame(1'b0);
        set_addr(1'b1, 8'h10, 1'b0);
        open_frame(2'b11); rd_word(8'hA5); close_frame(1'b0);
        // wrap at DEPTH-1, including a frame ending on the wrap
        set_addr(1'b0, 8'd199, 1'b0);
        open_frame(2'b01); wr_word(8'h11); close_frame(1'b0);
        open_frame(2'b01); wr_word(8'h22); wr_word(8'h33); close_frame(1'b0);
        set_addr(1'b1, 8'd199, 1'b0);
        open_frame(2'b11); rd_word(8'h11); rd_word(8'h22); rd_word(8'h33); close_frame(1'b0);
        // abort mid-write keeps mem[5] and wr_ptr
        set_addr(1'b0, 8'h05, 1'b0);
        open_frame(2'b01); wr_word(8'h5A); close_frame(1'b0);
        set_addr(1'b0, 8'h05, 1'b0);
        open_frame(2'b01);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
        close_frame(1'b1);
        set_addr(1'b1, 8'h05, 1'b0);
        open_frame(2'b11); rd_word(8'h5A); close_frame(1'b0);
        open_frame(2'b01); wr_word(8'h77); close_frame(1'b0);
        set_addr(1'b1, 8'h05, 1'b0);
        open_frame(2'b11); rd_word(8'h77); close_frame(1'b0);
        // abort during command
        fid++;
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        close_frame(1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        // abort mid-read: no error
        set_addr(1'b1, 8'h10, 1'b0);
        open_frame(2'b11);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        close_frame(1'b0);
        // out-of-range address clamps to 0
        set_addr(1'b0, 8'hF0, 1'b1);
        open_frame(2'b01); wr_word(8'h3C); close_frame(1'b0);
        set_addr(1'b1, 8'h00, 1'b0);
        open_frame(2'b11); rd_word(8'h3C); close_frame(1'b0);
`ifdef SPI_RAM_PARITY_EN
        set_addr(1'b0, 8'h20, 1'b0);
        open_frame(2'b01); wr_par(8'h07, 1'b0, 1'b1); wr_par(8'h07, 1'b1, 1'b0); close_frame(1'b0);
        set_addr(1'b1, 8'h20, 1'b0);
        open_frame(2'b11); rd_word(8'h07); close_frame(1'b0);
`endif
        // async reset right after E6 of a read of 0x77 (MISO high at that point)
        set_addr(1'b1, 8'h05, 1'b0);
        open_frame(2'b11);
        for (int i = 7; i >= 4; i--) tick(1'b0, 1'b0, w77[i], 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (MISO !== 1'b0 || frame_err !== 1'b0) begin
            bad++;
            $display("FAIL async_rst: MISO=%b frame_err=%b, required 0 0", MISO, frame_err);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        open_frame(2'b11); rd_word(8'h3C); close_frame(1'b0);
        @(posedge clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
